// File: rtl/decode_scoreboard_ctrl_if.sv
// Handshake and scoreboard signals between decode stage 1, decode stage 2 and writeback.
// The master drives stage-1/writeback/flush inputs; the slave is the scoreboard controller.
interface decode_scoreboard_ctrl_if;
  logic       d1_valid_i;
  logic [4:0] d1_rs1_i;
  logic [4:0] d1_rs2_i;
  logic [4:0] d1_rd_i;
  logic       d1_use_rs1_i;
  logic       d1_use_rs2_i;
  logic       d1_gr_we_i;
  logic       d1_ready_o;
  logic       d2_valid_o;
  logic       d2_ready_i;
  logic       wb_valid_i;
  logic       wb_we_i;
  logic [4:0] wb_rd_i;
  logic       flush_i;
  logic       busy_o;
  logic       err_o;

  modport master (
    output d1_valid_i, d1_rs1_i, d1_rs2_i, d1_rd_i, d1_use_rs1_i, d1_use_rs2_i, d1_gr_we_i,
    output d2_ready_i, wb_valid_i, wb_we_i, wb_rd_i, flush_i,
    input  d1_ready_o, d2_valid_o, busy_o, err_o
  );

  modport slave (
    input  d1_valid_i, d1_rs1_i, d1_rs2_i, d1_rd_i, d1_use_rs1_i, d1_use_rs2_i, d1_gr_we_i,
    input  d2_ready_i, wb_valid_i, wb_we_i, wb_rd_i, flush_i,
    output d1_ready_o, d2_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/decode_scoreboard_ctrl.sv
// Issue controller between decode stages: per-register pending-write counters block
// RAW hazards and saturation, and own the stage-1 to stage-2 valid/ready handshake.
module decode_scoreboard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  decode_scoreboard_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Entry 0 exists only so 5-bit indices stay in range; it is held at zero.
  logic [CNT_W-1:0] cnt_r [32];
  logic             d2_valid_r;
  logic             err_r;

  logic        rs1_haz_s;
  logic        rs2_haz_s;
  logic        sat_haz_s;
  logic        hazard_s;
  logic        ready_s;
  logic        fire_s;
  logic        inc_s;
  logic        dec_s;
  logic        busy_s;
  logic [31:0] inc_vec_s;
  logic [31:0] dec_vec_s;

  // Hazard detection, handshake and per-register update selects from pre-update counters.
  always_comb begin
    rs1_haz_s = bus.d1_use_rs1_i && (bus.d1_rs1_i != 5'd0) && (cnt_r[bus.d1_rs1_i] != CNT_ZERO);
    rs2_haz_s = bus.d1_use_rs2_i && (bus.d1_rs2_i != 5'd0) && (cnt_r[bus.d1_rs2_i] != CNT_ZERO);
    sat_haz_s = bus.d1_gr_we_i && (bus.d1_rd_i != 5'd0) && (cnt_r[bus.d1_rd_i] == CNT_MAX);
    hazard_s  = rs1_haz_s || rs2_haz_s || sat_haz_s;
    ready_s   = !rst_i && !bus.flush_i && !hazard_s && (!d2_valid_r || bus.d2_ready_i);
    fire_s    = bus.d1_valid_i && ready_s;
    inc_s     = fire_s && bus.d1_gr_we_i && (bus.d1_rd_i != 5'd0);
    dec_s     = bus.wb_valid_i && bus.wb_we_i && (bus.wb_rd_i != 5'd0);
    inc_vec_s = inc_s ? (32'd1 << bus.d1_rd_i) : 32'd0;
    dec_vec_s = dec_s ? (32'd1 << bus.wb_rd_i) : 32'd0;
  end

  // Busy whenever any tracked register still has a write in flight.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 1; i < 32; i++) begin
      busy_s = busy_s | (cnt_r[i] != CNT_ZERO);
    end
  end

  // Counter, stage-2 valid and sticky error state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      d2_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else if (bus.flush_i) begin
      // Writeback in the flush cycle is dropped along with everything in flight.
      for (int i = 0; i < 32; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      d2_valid_r <= 1'b0;
      err_r      <= err_r;
    end else begin
      cnt_r[0] <= CNT_ZERO;
      for (int i = 1; i < 32; i++) begin
        case ({inc_vec_s[i], dec_vec_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01:   cnt_r[i] <= (cnt_r[i] != CNT_ZERO) ? (cnt_r[i] - CNT_ONE) : CNT_ZERO;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      if (dec_s && (cnt_r[bus.wb_rd_i] == CNT_ZERO)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      if (fire_s) begin
        d2_valid_r <= 1'b1;
      end else if (bus.d2_ready_i) begin
        d2_valid_r <= 1'b0;
      end else begin
        d2_valid_r <= d2_valid_r;
      end
    end
  end

  assign bus.d1_ready_o = ready_s;
  assign bus.d2_valid_o = d2_valid_r;
  assign bus.busy_o     = busy_s;
  assign bus.err_o      = err_r;
endmodule

// File: tb/tb_decode_scoreboard_ctrl.sv
// Table-driven bench for decode_scoreboard_ctrl: per-cycle stimulus rows with expected
// combinational ready, and post-edge expectations queued and compared after the clock.
module tb_decode_scoreboard_ctrl;
  logic clk_i;
  logic rst_i;
  decode_scoreboard_ctrl_if bus ();

  decode_scoreboard_ctrl #(.CNT_W(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       rst;
    bit       v;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       we;
    bit       dr;
    bit       wbv;
    bit       wbwe;
    bit [4:0] wbrd;
    bit       fl;
    bit       rdy;
    bit       d2v;
    bit       busy;
    bit       err;
  } row_t;

  typedef struct {
    bit d2v;
    bit busy;
    bit err;
    int idx;
  } exp_t;

  row_t vec[$];
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic row_t mk(bit rst, bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit we, bit dr, bit wbv, bit wbwe, bit [4:0] wbrd,
                              bit fl, bit rdy, bit d2v, bit busy, bit err);
    row_t r;
    r.rst = rst; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.we = we; r.dr = dr; r.wbv = wbv; r.wbwe = wbwe; r.wbrd = wbrd;
    r.fl = fl; r.rdy = rdy; r.d2v = d2v; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %0b, expected %0b", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic apply(input row_t r, input int idx);
    exp_t e;
    @(negedge clk_i);
    rst_i            = r.rst;
    bus.d1_valid_i   = r.v;
    bus.d1_rs1_i     = r.rs1;
    bus.d1_use_rs1_i = r.u1;
    bus.d1_rs2_i     = r.rs2;
    bus.d1_use_rs2_i = r.u2;
    bus.d1_rd_i      = r.rd;
    bus.d1_gr_we_i   = r.we;
    bus.d2_ready_i   = r.dr;
    bus.wb_valid_i   = r.wbv;
    bus.wb_we_i      = r.wbwe;
    bus.wb_rd_i      = r.wbrd;
    bus.flush_i      = r.fl;
    #1;
    check("d1_ready", idx, bus.d1_ready_o, r.rdy);
    e.d2v = r.d2v; e.busy = r.busy; e.err = r.err; e.idx = idx;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", idx, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      check("d2_valid", e.idx, bus.d2_valid_o, e.d2v);
      check("busy", e.idx, bus.busy_o, e.busy);
      check("err", e.idx, bus.err_o, e.err);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.d1_valid_i = 1'b0; bus.d1_rs1_i = 5'd0; bus.d1_rs2_i = 5'd0; bus.d1_rd_i = 5'd0;
    bus.d1_use_rs1_i = 1'b0; bus.d1_use_rs2_i = 1'b0; bus.d1_gr_we_i = 1'b0;
    bus.d2_ready_i = 1'b0; bus.wb_valid_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_rd_i = 5'd0;
    bus.flush_i = 1'b0;

    //            rst v  rs1 u1 rs2 u2 rd  we dr wbv wbwe wbrd fl  rdy d2v busy err
    // reset held with a valid instruction waiting
    vec.push_back(mk(1, 1, 0,  0, 0,  0, 5,  1, 1, 0, 0, 0,  0,  0, 0, 0, 0));
    vec.push_back(mk(1, 1, 0,  0, 0,  0, 5,  1, 1, 0, 0, 0,  0,  0, 0, 0, 0));
    // RAW: addi x5 then add x6,x5,x1
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 5,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 5,  1, 1,  1, 6,  1, 1, 0, 0, 0,  0,  0, 0, 1, 0));
    vec.push_back(mk(0, 1, 5,  1, 1,  1, 6,  1, 1, 1, 0, 5,  0,  0, 0, 1, 0));
    vec.push_back(mk(0, 1, 5,  1, 1,  1, 6,  1, 1, 1, 1, 5,  0,  0, 0, 0, 0));
    vec.push_back(mk(0, 1, 5,  1, 1,  1, 6,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 6,  0,  1, 0, 0, 0));
    // saturation on x7
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  0, 0, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 1, 1, 7,  0,  0, 0, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 7,  1, 1, 0, 0, 0,  0,  0, 0, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 7,  0,  1, 0, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 7,  0,  1, 0, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 7,  0,  1, 0, 0, 0));
    // simultaneous increment and decrement on x3
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 3,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 3,  1, 1, 1, 1, 3,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 3,  0,  1, 0, 0, 0));
    // x0 is never tracked
    vec.push_back(mk(0, 1, 0,  1, 0,  1, 0,  1, 1, 0, 0, 0,  0,  1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 0,  0,  1, 0, 0, 0));
    // back-pressure from stage 2
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 10, 1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 11, 1, 0, 0, 0, 0,  0,  0, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 11, 1, 0, 0, 0, 0,  0,  0, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 11, 1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 0,  0,  1, 0, 1, 0));
    // flush with cnt5=2, cnt9=1, then an orphan writeback to x9
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 5,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 5,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 9,  1, 1, 0, 0, 0,  0,  1, 1, 1, 0));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 12, 1, 0, 1, 1, 5,  1,  0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 1, 9,  0,  1, 0, 0, 1));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 0,  0,  1, 0, 0, 1));
    vec.push_back(mk(0, 1, 0,  0, 0,  0, 4,  1, 1, 0, 0, 0,  0,  1, 1, 1, 1));
    // reset mid-operation clears error and in-flight state
    vec.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 0,  0,  0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 0,  0,  1, 0, 0, 0));

    for (int i = 0; i < vec.size(); i++) begin
      apply(vec[i], i);
    end

    // back-to-back independent writes issue every cycle, then drain via writeback
    for (int i = 0; i < 6; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 5'(13 + i), 1, 1, 0, 0, 0, 0, 1, 1, 1, 0), 100 + i);
    end
    for (int i = 0; i < 6; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'(13 + i), 0, 1, 0, (i < 5), 0), 200 + i);
    end

    check("scoreboard_drained", 999, (exp_q.size() == 0), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
